// File: rtl/microsequencer.sv
// Microprogram sequencer: owns the control address register (car), computes the
// next microaddress, and registers the control word onto cs_bus. Supports branching
// on condition flags, a micro-subroutine return stack and WMFC/MFC stalls.
// The control store is external and combinational, indexed by car.
// Configuration macro: MICROSEQ_STACK_EN enables CALL/RET with a STACK_DEPTH x AW
// return stack; when undefined, CALL and RET are illegal and raise stack_err.
module microsequencer #(
  parameter int AW          = 7,
  parameter int CW          = 28,
  parameter int NF          = 4,
  parameter int STACK_DEPTH = 4,
  parameter int WMFC_BIT    = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AW-1:0]         map_addr,
  input  logic [CW-1:0]         uword_ctl,
  input  logic [2:0]            uword_op,
  input  logic [$clog2(NF)-1:0] uword_cond,
  input  logic [AW-1:0]         uword_next,
  input  logic [NF-1:0]         flags,
  input  logic                  mfc,
  output logic [AW-1:0]         car,
  output logic [CW-1:0]         cs_bus,
  output logic                  busy,
  output logic                  stack_err
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_e;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JMP, OP_BT, OP_BF, OP_CALL, OP_RET, OP_MAP, OP_END
  } op_e;

  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("microsequencer: STACK_DEPTH must be at least 1");
  end

  state_e        state;
  op_e           op;
  logic [AW-1:0] car_inc;
  logic [AW-1:0] next_car;
  logic          cond_flag;
  logic          stall;
  logic          fault;
  logic          finish;
  logic          push;
  logic          pop;

`ifdef MICROSEQ_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  stack [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;

  assign sp_m1 = sp - SPW'(1);
`endif

  assign op      = op_e'(uword_op);
  assign car_inc = car + AW'(1);
  assign stall   = uword_ctl[WMFC_BIT] & ~mfc;

  // Decode the current microword's sequencing op into next address and stack actions
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    next_car  = car_inc;
    cond_flag = flags[uword_cond];
    fault     = 1'b0;
    finish    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (op)
      OP_NEXT: next_car = car_inc;
      OP_JMP:  next_car = uword_next;
      OP_BT:   if (cond_flag)  next_car = uword_next;
      OP_BF:   if (!cond_flag) next_car = uword_next;
`ifdef MICROSEQ_STACK_EN
      OP_CALL: begin
        if (sp == SPW'(STACK_DEPTH)) fault = 1'b1;
        else begin
          push     = 1'b1;
          next_car = uword_next;
        end
      end
      OP_RET: begin
        if (sp == '0) fault = 1'b1;
        else begin
          pop      = 1'b1;
          next_car = stack[sp_m1[IW-1:0]];
        end
      end
`else
      OP_CALL: fault = 1'b1;
      OP_RET:  fault = 1'b1;
`endif
      OP_MAP:  next_car = map_addr;
      OP_END:  finish = 1'b1;
      default: finish = 1'b1;
    endcase
  end

`ifdef MICROSEQ_STACK_EN
  // Return-address storage; written only on an executed, non-faulting CALL
  always_ff @(posedge CLK) begin
    // NOTE: the stack array carries no reset; sp alone marks which entries are valid.
    if (state != IDLE && !stall && push) stack[sp[IW-1:0]] <= car_inc;
  end
`endif

  // Sequencer FSM: car, cs_bus, busy, stack_err and sp are all registered here
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      car       <= '0;
      cs_bus    <= '0;
      busy      <= 1'b0;
      stack_err <= 1'b0;
`ifdef MICROSEQ_STACK_EN
      sp        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          car    <= '0;
          cs_bus <= '0;
          if (start) begin
            busy      <= 1'b1;
            stack_err <= 1'b0;
`ifdef MICROSEQ_STACK_EN
            sp        <= '0;
`endif
            state     <= RUN;
          end
        end
        RUN, WAIT: begin
          if (stall) begin
            cs_bus <= uword_ctl;
            state  <= WAIT;
          end else if (fault || finish) begin
            car    <= '0;
            cs_bus <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
            if (fault) begin
              stack_err <= 1'b1;
`ifdef MICROSEQ_STACK_EN
              sp        <= '0;
`endif
            end
          end else begin
            car    <= next_car;
            cs_bus <= uword_ctl;
            state  <= RUN;
`ifdef MICROSEQ_STACK_EN
            if (push)     sp <= sp + SPW'(1);
            else if (pop) sp <= sp_m1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer. The bench owns the control-store model;
// expected car/cs_bus/busy/stack_err per cycle are queued before each run and
// popped as the DUT steps. Honours MICROSEQ_STACK_EN the same way as the RTL.
module tb_microsequencer;

  localparam int AW = 7;
  localparam int CW = 28;
  localparam int NF = 4;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JMP = 3'd1, OP_BT = 3'd2, OP_BF = 3'd3,
                         OP_CALL = 3'd4, OP_RET = 3'd5, OP_MAP = 3'd6, OP_END = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] map_addr = '0;
  logic [CW-1:0] uword_ctl;
  logic [2:0]    uword_op;
  logic [1:0]    uword_cond;
  logic [AW-1:0] uword_next;
  logic [NF-1:0] flags = '0;
  logic          mfc = 1'b1;
  logic [AW-1:0] car;
  logic [CW-1:0] cs_bus;
  logic          busy;
  logic          stack_err;

  logic [CW-1:0] rom_ctl  [128];
  logic [2:0]    rom_op   [128];
  logic [1:0]    rom_cond [128];
  logic [AW-1:0] rom_next [128];

  assign uword_ctl  = rom_ctl[car];
  assign uword_op   = rom_op[car];
  assign uword_cond = rom_cond[car];
  assign uword_next = rom_next[car];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] car;
    logic [CW-1:0] cs;
    logic          busy;
    logic          err;
    logic          mfc_n;
    logic [NF-1:0] flags_n;
    logic          start_n;
  } exp_t;

  exp_t sb[$];

  microsequencer dut (
    .CLK(clk), .reset(reset), .start(start), .map_addr(map_addr),
    .uword_ctl(uword_ctl), .uword_op(uword_op), .uword_cond(uword_cond),
    .uword_next(uword_next), .flags(flags), .mfc(mfc), .car(car),
    .cs_bus(cs_bus), .busy(busy), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] c(input logic [AW-1:0] a);
    return 28'hA50_0000 | {21'd0, a};
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 128; a++) begin
      rom_ctl[a]  = c(AW'(a));
      rom_op[a]   = OP_END;
      rom_cond[a] = 2'd0;
      rom_next[a] = '0;
    end
  endtask

  task automatic set_word(input int a, input logic [2:0] op, input logic [AW-1:0] nxt = '0,
                          input logic [1:0] cond = 2'd0);
    rom_op[a]   = op;
    rom_next[a] = nxt;
    rom_cond[a] = cond;
  endtask

  // Expected state after the next clock edge, plus inputs to drive for the edge after it
  task automatic sb_push(input logic [AW-1:0] e_car, input logic [CW-1:0] e_cs,
                         input logic e_busy, input logic e_err, input logic mfc_n = 1'b1,
                         input logic [NF-1:0] flags_n = '0, input logic start_n = 1'b0);
    exp_t e;
    e.car = e_car; e.cs = e_cs; e.busy = e_busy; e.err = e_err;
    e.mfc_n = mfc_n; e.flags_n = flags_n; e.start_n = start_n;
    sb.push_back(e);
  endtask

  // Pulse start, then step one edge per queued entry and compare at the falling edge
  task automatic run_sb(input string name);
    exp_t e;
    int   step;
    step  = 0;
    start = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (car !== e.car) begin
        n_fail++;
        $display("FAIL %s step %0d car: got %h expected %h", name, step, car, e.car);
      end
      n_checks++;
      if (cs_bus !== e.cs) begin
        n_fail++;
        $display("FAIL %s step %0d cs_bus: got %h expected %h", name, step, cs_bus, e.cs);
      end
      n_checks++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s step %0d busy: got %b expected %b", name, step, busy, e.busy);
      end
      n_checks++;
      if (stack_err !== e.err) begin
        n_fail++;
        $display("FAIL %s step %0d stack_err: got %b expected %b", name, step, stack_err, e.err);
      end
      start = e.start_n;
      mfc   = e.mfc_n;
      flags = e.flags_n;
      step++;
    end
    start = 1'b0;
    mfc   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({car, cs_bus, busy, stack_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got car=%h cs=%h busy=%b err=%b expected all zero",
               car, cs_bus, busy, stack_err);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || car !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got car=%h busy=%b expected car=0 busy=0", car, busy);
    end
  endtask

  task automatic test_map();
    clear_rom();
    set_word(0, OP_NEXT);
    set_word(1, OP_MAP);
    map_addr = 7'h20;
    sb_push(7'h00, '0,     1, 0);
    sb_push(7'h01, c(0),   1, 0);
    sb_push(7'h20, c(1),   1, 0);
    sb_push(7'h00, '0,     0, 0);
    run_sb("map");
  endtask

  task automatic test_branch();
    clear_rom();
    set_word(0, OP_BT, 7'h10, 2'd2);
    flags = 4'b0100;
    sb_push(7'h00, '0,   1, 0, 1, 4'b0100);
    sb_push(7'h10, c(0), 1, 0);
    sb_push(7'h00, '0,   0, 0);
    run_sb("bt_taken");
    flags = 4'b0000;
    sb_push(7'h00, '0,   1, 0, 1, 4'b0000);
    sb_push(7'h01, c(0), 1, 0);
    sb_push(7'h00, '0,   0, 0);
    run_sb("bt_not_taken");
    set_word(0, OP_BF, 7'h10, 2'd1);
    flags = 4'b1101;
    sb_push(7'h00, '0,   1, 0, 1, 4'b1101);
    sb_push(7'h10, c(0), 1, 0);
    sb_push(7'h00, '0,   0, 0);
    run_sb("bf_taken");
  endtask

  task automatic test_wrap();
    clear_rom();
    set_word(0, OP_BT, 7'h7F, 2'd0);
    set_word(127, OP_NEXT);
    flags = 4'b0001;
    sb_push(7'h00, '0,       1, 0, 1, 4'b0001);
    sb_push(7'h7F, c(0),     1, 0, 1, 4'b0000);
    sb_push(7'h00, c(7'h7F), 1, 0);
    sb_push(7'h01, c(0),     1, 0);
    sb_push(7'h00, '0,       0, 0);
    run_sb("wrap");
  endtask

  task automatic test_wmfc();
    clear_rom();
    set_word(0, OP_NEXT);
    rom_ctl[0] = 28'h0C0_0100;
    sb_push(7'h00, '0,          1, 0, 0);
    sb_push(7'h00, 28'h0C00100, 1, 0, 0);
    sb_push(7'h00, 28'h0C00100, 1, 0, 0);
    sb_push(7'h00, 28'h0C00100, 1, 0, 1);
    sb_push(7'h01, 28'h0C00100, 1, 0, 1);
    sb_push(7'h00, '0,          0, 0);
    run_sb("wmfc_stall");
    sb_push(7'h00, '0,          1, 0, 1);
    sb_push(7'h01, 28'h0C00100, 1, 0, 1);
    sb_push(7'h00, '0,          0, 0);
    run_sb("wmfc_mfc_same_cycle");
  endtask

  task automatic test_call();
    clear_rom();
    for (int a = 0; a < 3; a++) set_word(a, OP_NEXT);
    set_word(3, OP_CALL, 7'h30);
    set_word(7'h30, OP_RET);
    sb_push(7'h00, '0,   1, 0);
    sb_push(7'h01, c(0), 1, 0);
    sb_push(7'h02, c(1), 1, 0);
`ifdef MICROSEQ_STACK_EN
    sb_push(7'h03, c(2),     1, 0);
    sb_push(7'h30, c(3),     1, 0);
    sb_push(7'h04, c(7'h30), 1, 0);
    sb_push(7'h00, '0,       0, 0);
`else
    sb_push(7'h03, c(2), 1, 0);
    sb_push(7'h00, '0,   0, 1);
`endif
    run_sb("call_ret");
  endtask

  task automatic test_nested();
    clear_rom();
    set_word(0, OP_CALL, 7'h40);
    for (int a = 0; a < 4; a++) set_word(7'h40 + a, OP_CALL, AW'(7'h41 + a));
    sb_push(7'h00, '0, 1, 0);
`ifdef MICROSEQ_STACK_EN
    sb_push(7'h40, c(0),     1, 0);
    sb_push(7'h41, c(7'h40), 1, 0);
    sb_push(7'h42, c(7'h41), 1, 0);
    sb_push(7'h43, c(7'h42), 1, 0);
`endif
    sb_push(7'h00, '0, 0, 1);
    run_sb("nested_overflow");
  endtask

  task automatic test_ret_empty();
    clear_rom();
    set_word(0, OP_RET);
    sb_push(7'h00, '0, 1, 0);
    sb_push(7'h00, '0, 0, 1);
    run_sb("ret_empty");
  endtask

  task automatic test_back_to_back();
    clear_rom();
    set_word(0, OP_NEXT);
    set_word(1, OP_NEXT);
    sb_push(7'h00, '0,   1, 0, 1, '0, 1);
    sb_push(7'h01, c(0), 1, 0, 1, '0, 1);
    sb_push(7'h02, c(1), 1, 0, 1, '0, 1);
    sb_push(7'h00, '0,   0, 0, 1, '0, 1);
    sb_push(7'h00, '0,   1, 0, 1, '0, 0);
    sb_push(7'h01, c(0), 1, 0);
    sb_push(7'h02, c(1), 1, 0);
    sb_push(7'h00, '0,   0, 0);
    run_sb("back_to_back");
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    clear_rom();
    for (int a = 0; a < 12; a++) set_word(a, OP_NEXT);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (car !== 7'h05 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (car !== 7'h05) begin
      n_fail++;
      $display("FAIL reset_mid_run_reach: got car=%h expected 05 within 20 cycles", car);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({car, cs_bus, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run_async: got car=%h cs=%h busy=%b expected all zero",
               car, cs_bus, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_map();
    test_branch();
    test_wrap();
    test_wmfc();
    test_call();
    test_nested();
    test_call();
    test_ret_empty();
    test_back_to_back();
    test_reset_mid_run();
    test_map();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
